// File: rtl/golf_turn_engine_if.sv
// Map-read and trig-lookup handshakes between golf_turn_engine (master) and its
// tile memory / cos-sin table (slave).
interface golf_turn_engine_if;
  logic        tile_req;
  logic [15:0] tile_addr;
  logic        tile_valid;
  logic [1:0]  tile_type;
  logic        trig_req;
  logic [15:0] trig_angle;
  logic        trig_valid;
  logic [15:0] cos_abs;
  logic [15:0] sin_abs;
  logic        cos_sign;
  logic        sin_sign;

  modport master (
    output tile_req, tile_addr, trig_req, trig_angle,
    input  tile_valid, tile_type, trig_valid, cos_abs, sin_abs, cos_sign, sin_sign
  );

  modport slave (
    input  tile_req, tile_addr, trig_req, trig_angle,
    output tile_valid, tile_type, trig_valid, cos_abs, sin_abs, cos_sign, sin_sign
  );
endinterface

// File: rtl/golf_turn_engine.sv
// Turn-based mini-golf engine: charge, aim, per-frame tile probing, reflect/move, turn rotation.
// Optional stroke cap enabled by defining GOLF_STROKE_LIMIT_EN.
module golf_turn_engine #(
  parameter int unsigned NUM_PLAYERS        = 2,
  parameter int unsigned MAP_WIDTH          = 160,
  parameter int unsigned MAP_HEIGHT         = 90,
  parameter int unsigned START_X            = 10,
  parameter int unsigned START_Y            = 10,
  parameter int unsigned GRASS_DECEL        = 2,
  parameter int unsigned SAND_DECEL         = 10,
  parameter logic [15:0] MAX_INIT_SPEED     = 16'h0200,
  parameter logic [15:0] MAX_SPEED_TO_SCORE = 16'h0080,
  parameter int unsigned CHARGE_DIV         = 390625,
  parameter int unsigned MAX_STROKES        = 10,
  localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     new_frame,
  input  logic                     charging_hit,
  input  logic [15:0]              aim_angle,
  golf_turn_engine_if.master       bus,
  output logic [PW-1:0]            active_player,
  output logic [15:0]              ball_x,
  output logic [15:0]              ball_y,
  output logic [15:0]              ball_speed,
  output logic [15:0]              ball_direction,
  output logic [8*NUM_PLAYERS-1:0] strokes,
  output logic [NUM_PLAYERS-1:0]   done_mask,
  output logic [2:0]               state_out,
  output logic                     game_over
);

  typedef enum logic [2:0] {
    S_RESTING   = 3'd0,
    S_CHARGING  = 3'd1,
    S_AIM       = 3'd2,
    S_PROBE     = 3'd3,
    S_UPDATE    = 3'd4,
    S_REFLECT   = 3'd5,
    S_NEXT_TURN = 3'd6,
    S_GAME_OVER = 3'd7
  } state_e;

  localparam logic [1:0]  T_HOLE   = 2'd0;
  localparam logic [1:0]  T_WALL   = 2'd1;
  localparam logic [1:0]  T_GRASS  = 2'd2;
  localparam logic [1:0]  T_SAND   = 2'd3;
  localparam logic [8:0]  MW9      = 9'(MAP_WIDTH);
  localparam logic [8:0]  MH9      = 9'(MAP_HEIGHT);
  localparam logic [15:0] MW16     = 16'(MAP_WIDTH);
  localparam logic [15:0] GD       = 16'(GRASS_DECEL);
  localparam logic [15:0] SD       = 16'(SAND_DECEL);
  localparam logic [31:0] DIV_LAST = 32'(CHARGE_DIV - 1);
  localparam logic [15:0] X_RST    = {8'(START_X), 8'h00};
  localparam logic [15:0] Y_RST    = {8'(START_Y), 8'h00};
  localparam logic [7:0]  CAP      = 8'(MAX_STROKES);
`ifdef GOLF_STROKE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [PW-1:0]       active_q, active_d;
  logic [15:0]         x_q [NUM_PLAYERS];
  logic [15:0]         x_d [NUM_PLAYERS];
  logic [15:0]         y_q [NUM_PLAYERS];
  logic [15:0]         y_d [NUM_PLAYERS];
  logic [7:0]          strokes_q [NUM_PLAYERS];
  logic [7:0]          strokes_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] done_q, done_d;
  logic [15:0]         speed_q, speed_d, dir_q, dir_d;
  logic [15:0]         cos_q, cos_d, sin_q, sin_d;
  logic                cos_s_q, cos_s_d, sin_s_q, sin_s_d;
  logic                charge_up_q, charge_up_d, trig_done_q, trig_done_d, moved_q, moved_d;
  logic [31:0]         div_q, div_d;
  logic [2:0]          probe_idx_q, probe_idx_d;
  logic [1:0]          tiles_q [5];
  logic [1:0]          tiles_d [5];

  logic [15:0] cur_x, cur_y, n_addr, dx, dy, decel, dir_xr, dir_yr;
  logic [8:0]  nx, ny;
  logic        under, n_oob, any_left;
  logic [PW-1:0] nxt_player;
  int unsigned cand;

  // Integer coordinates of the tile currently being probed; a step below 0 is caught before it wraps
  always_comb begin
    cur_x = x_q[active_q];
    cur_y = y_q[active_q];
    nx    = {1'b0, cur_x[15:8]};
    ny    = {1'b0, cur_y[15:8]};
    under = 1'b0;
    case (probe_idx_q)
      3'd1: nx = nx + 9'd1;
      3'd2: ny = ny + 9'd1;
      3'd3: begin under = (nx == '0); nx = nx - 9'd1; end
      3'd4: begin under = (ny == '0); ny = ny - 9'd1; end
      default: ;
    endcase
    n_oob  = under || (nx >= MW9) || (ny >= MH9);
    n_addr = 16'(nx) + MW16 * 16'(ny);
  end

  always_comb begin
    dx     = 16'((32'(speed_q) * 32'(cos_q)) >> 8);
    dy     = 16'((32'(speed_q) * 32'(sin_q)) >> 8);
    dir_xr = (dir_q <= 16'd180) ? 16'd180 - dir_q : 16'd540 - dir_q;
    dir_yr = (dir_q == '0) ? '0 : 16'd360 - dir_q;
    case (tiles_q[0])
      T_GRASS: decel = GD;
      T_SAND:  decel = SD;
      default: decel = '0;
    endcase
  end

  // First unfinished player after the active one, wrapping back to the active one last
  always_comb begin
    nxt_player = active_q;
    any_left   = 1'b0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_PLAYERS; k++) begin
      cand = (32'(active_q) + k) % NUM_PLAYERS;
      if (!any_left && !done_q[PW'(cand)]) begin
        any_left   = 1'b1;
        nxt_player = PW'(cand);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= S_RESTING;
      active_q    <= '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        x_q[p]       <= X_RST;
        y_q[p]       <= Y_RST;
        strokes_q[p] <= '0;
      end
      done_q      <= '0;
      speed_q     <= '0;
      dir_q       <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      cos_s_q     <= 1'b1;
      sin_s_q     <= 1'b1;
      charge_up_q <= 1'b1;
      trig_done_q <= 1'b0;
      moved_q     <= 1'b0;
      div_q       <= '0;
      probe_idx_q <= '0;
      for (int unsigned t = 0; t < 5; t++) tiles_q[t] <= T_GRASS;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      x_q         <= x_d;
      y_q         <= y_d;
      strokes_q   <= strokes_d;
      done_q      <= done_d;
      speed_q     <= speed_d;
      dir_q       <= dir_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      cos_s_q     <= cos_s_d;
      sin_s_q     <= sin_s_d;
      charge_up_q <= charge_up_d;
      trig_done_q <= trig_done_d;
      moved_q     <= moved_d;
      div_q       <= div_d;
      probe_idx_q <= probe_idx_d;
      tiles_q     <= tiles_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    x_d         = x_q;
    y_d         = y_q;
    strokes_d   = strokes_q;
    done_d      = done_q;
    speed_d     = speed_q;
    dir_d       = dir_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    cos_s_d     = cos_s_q;
    sin_s_d     = sin_s_q;
    charge_up_d = charge_up_q;
    trig_done_d = trig_done_q;
    moved_d     = moved_q;
    div_d       = div_q;
    probe_idx_d = probe_idx_q;
    tiles_d     = tiles_q;
    case (state_q)
      S_RESTING: begin
        if (charging_hit) begin
          state_d     = S_CHARGING;
          speed_d     = '0;
          charge_up_d = 1'b1;
          div_d       = '0;
        end
      end
      S_CHARGING: begin
        if (!charging_hit) begin
          if (speed_q == '0) begin
            state_d = S_RESTING;
          end else begin
            if (strokes_q[active_q] != 8'hFF) strokes_d[active_q] = strokes_q[active_q] + 8'd1;
            dir_d       = aim_angle;
            trig_done_d = 1'b0;
            state_d     = S_AIM;
          end
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (charge_up_q) begin
            speed_d = speed_q + 16'd1;
            if (speed_q + 16'd1 >= MAX_INIT_SPEED) charge_up_d = 1'b0;
          end else begin
            speed_d = speed_q - 16'd1;
            if (speed_q <= 16'd1) charge_up_d = 1'b1;
          end
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      S_AIM, S_REFLECT: begin
        if (!trig_done_q) begin
          if (bus.trig_valid) begin
            cos_d       = bus.cos_abs;
            sin_d       = bus.sin_abs;
            cos_s_d     = bus.cos_sign;
            sin_s_d     = bus.sin_sign;
            trig_done_d = 1'b1;
          end
        end else if (new_frame) begin
          state_d     = S_PROBE;
          probe_idx_d = '0;
        end
      end
      S_PROBE: begin
        // Off-map neighbours resolve as walls in the same cycle without touching the bus
        if (n_oob || bus.tile_valid) begin
          tiles_d[probe_idx_q] = n_oob ? T_WALL : bus.tile_type;
          if (probe_idx_q == 3'd4) begin
            state_d = S_UPDATE;
            moved_d = 1'b0;
          end else begin
            probe_idx_d = probe_idx_q + 3'd1;
          end
        end
      end
      S_UPDATE: begin
        if (moved_q) begin
          if (new_frame) begin
            state_d     = S_PROBE;
            probe_idx_d = '0;
          end
        end else if (tiles_q[0] == T_HOLE && speed_q < MAX_SPEED_TO_SCORE) begin
          done_d[active_q] = 1'b1;
          speed_d          = '0;
          state_d          = S_NEXT_TURN;
        end else if (speed_q == '0) begin
          if (LIMIT_EN && strokes_q[active_q] == CAP) done_d[active_q] = 1'b1;
          state_d = S_NEXT_TURN;
        end else if (tiles_q[1] == T_WALL) begin
          x_d[active_q] = {cur_x[15:8] - 8'd1, 8'h80};
          dir_d         = dir_xr;
          trig_done_d   = 1'b0;
          state_d       = S_REFLECT;
        end else if (tiles_q[2] == T_WALL) begin
          y_d[active_q] = {cur_y[15:8] - 8'd1, 8'h80};
          dir_d         = dir_yr;
          trig_done_d   = 1'b0;
          state_d       = S_REFLECT;
        end else if (tiles_q[3] == T_WALL) begin
          x_d[active_q] = {cur_x[15:8] + 8'd1, 8'h80};
          dir_d         = dir_xr;
          trig_done_d   = 1'b0;
          state_d       = S_REFLECT;
        end else if (tiles_q[4] == T_WALL) begin
          y_d[active_q] = {cur_y[15:8] + 8'd1, 8'h80};
          dir_d         = dir_yr;
          trig_done_d   = 1'b0;
          state_d       = S_REFLECT;
        end else begin
          // Displacement uses the speed held during this frame; decel applies afterwards
          speed_d       = (speed_q > decel) ? speed_q - decel : '0;
          x_d[active_q] = cos_s_q ? cur_x + dx : cur_x - dx;
          y_d[active_q] = sin_s_q ? cur_y + dy : cur_y - dy;
          moved_d       = 1'b1;
        end
      end
      S_NEXT_TURN: begin
        if (any_left) begin
          active_d = nxt_player;
          speed_d  = '0;
          state_d  = S_RESTING;
        end else begin
          state_d = S_GAME_OVER;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.tile_req   = (state_q == S_PROBE) && !n_oob;
    bus.tile_addr  = n_addr;
    bus.trig_req   = ((state_q == S_AIM) || (state_q == S_REFLECT)) && !trig_done_q;
    bus.trig_angle = dir_q;
    active_player  = active_q;
    ball_x         = cur_x;
    ball_y         = cur_y;
    ball_speed     = speed_q;
    ball_direction = dir_q;
    strokes        = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) strokes[8*p +: 8] = strokes_q[p];
    done_mask      = done_q;
    state_out      = state_q;
    game_over      = (state_q == S_GAME_OVER);
  end

endmodule

// File: tb/tb_golf_turn_engine.sv
// Directed bench: three players on a grass map with a wall at (2,10) and a hole toggled at (1,10).
module tb_golf_turn_engine;
  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_frame = 1'b0;
  logic        charging_hit = 1'b0;
  logic [15:0] aim_angle = '0;
  logic [1:0]  active_player;
  logic [15:0] ball_x, ball_y, ball_speed, ball_direction;
  logic [23:0] strokes;
  logic [2:0]  done_mask;
  logic [2:0]  state_out;
  logic        game_over;

  logic [1:0]  map_mem [0:14399];
  logic        trig_en = 1'b1;
  int unsigned reads = 0;
  int unsigned frame_cnt = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  golf_turn_engine_if bus ();

  golf_turn_engine #(
    .NUM_PLAYERS (3),
    .START_X     (1),
    .START_Y     (10),
    .CHARGE_DIV  (DIV),
    .MAX_STROKES (2)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .new_frame      (new_frame),
    .charging_hit   (charging_hit),
    .aim_angle      (aim_angle),
    .bus            (bus),
    .active_player  (active_player),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .ball_speed     (ball_speed),
    .ball_direction (ball_direction),
    .strokes        (strokes),
    .done_mask      (done_mask),
    .state_out      (state_out),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_cnt == 19) begin
      frame_cnt <= 0;
      new_frame <= 1'b1;
    end else begin
      frame_cnt <= frame_cnt + 1;
      new_frame <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.tile_valid <= 1'b0;
      bus.tile_type  <= 2'd2;
    end else begin
      bus.tile_valid <= 1'b0;
      if (bus.tile_req && !bus.tile_valid) begin
        bus.tile_valid <= 1'b1;
        bus.tile_type  <= map_mem[bus.tile_addr];
      end
      if (bus.tile_req && bus.tile_valid) reads <= reads + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.trig_valid <= 1'b0;
      bus.cos_abs    <= '0;
      bus.sin_abs    <= '0;
      bus.cos_sign   <= 1'b1;
      bus.sin_sign   <= 1'b1;
    end else begin
      bus.trig_valid <= 1'b0;
      if (bus.trig_req && !bus.trig_valid && trig_en) begin
        bus.trig_valid <= 1'b1;
        case (bus.trig_angle)
          16'd90:  begin bus.cos_abs <= 16'h0000; bus.cos_sign <= 1'b1; bus.sin_abs <= 16'h0100; bus.sin_sign <= 1'b1; end
          16'd180: begin bus.cos_abs <= 16'h0100; bus.cos_sign <= 1'b0; bus.sin_abs <= 16'h0000; bus.sin_sign <= 1'b1; end
          16'd270: begin bus.cos_abs <= 16'h0000; bus.cos_sign <= 1'b1; bus.sin_abs <= 16'h0100; bus.sin_sign <= 1'b0; end
          default: begin bus.cos_abs <= 16'h0100; bus.cos_sign <= 1'b1; bus.sin_abs <= 16'h0000; bus.sin_sign <= 1'b1; end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int unsigned n;
    n = 0;
    while (state_out !== s && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state_out), 32'(s));
  endtask

  task automatic charge(input int unsigned steps, input logic [15:0] ang);
    aim_angle = ang;
    charging_hit = 1'b1;
    @(negedge clk);
    repeat (steps * DIV) @(negedge clk);
    charging_hit = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 14400; i++) map_mem[i] = 2'd2;
    map_mem[1602] = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_state",   32'(state_out), 32'd0);
    check("rst_active",  32'(active_player), 32'd0);
    check("rst_x",       32'(ball_x), 32'h0100);
    check("rst_y",       32'(ball_y), 32'h0A00);
    check("rst_speed",   32'(ball_speed), 32'd0);
    check("rst_dir",     32'(ball_direction), 32'd0);
    check("rst_strokes", 32'(strokes), 32'd0);
    check("rst_done",    32'(done_mask), 32'd0);
    check("rst_gover",   32'(game_over), 32'd0);
    check("rst_treq",    32'(bus.tile_req), 32'd0);
    check("rst_rreq",    32'(bus.trig_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-speed release
    charging_hit = 1'b1;
    @(negedge clk);
    check("charge_enter", 32'(state_out), 32'd1);
    charging_hit = 1'b0;
    @(negedge clk);
    check("zero_rel_state",   32'(state_out), 32'd0);
    check("zero_rel_strokes", 32'(strokes), 32'd0);

    // player 0: speed 3, heading into the x+ wall
    charge(3, 16'd0);
    check("p0_aim_state", 32'(state_out), 32'd2);
    check("p0_speed",     32'(ball_speed), 32'd3);
    check("p0_strokes",   32'(strokes[7:0]), 32'd1);
    check("p0_trig_req",  32'(bus.trig_req), 32'd1);
    check("p0_trig_ang",  32'(bus.trig_angle), 32'd0);
    wait_state("reflect_xp", 3'd5);
    check("reflect_xp_x",   32'(ball_x), 32'h0080);
    check("reflect_xp_dir", 32'(ball_direction), 32'd180);
    check("reflect_xp_rd",  reads, 32'd5);
    map_mem[1602] = 2'd2;
    wait_state("probe_edge", 3'd3);
    wait_state("reflect_xm", 3'd5);
    check("reflect_xm_x",   32'(ball_x), 32'h0180);
    check("reflect_xm_dir", 32'(ball_direction), 32'd0);
    check("reflect_xm_rd",  reads, 32'd9);
    wait_state("p0_stop", 3'd0);
    check("p0_stop_active", 32'(active_player), 32'd1);
    check("p1_own_x",       32'(ball_x), 32'h0100);
    check("p0_stop_done",   32'(done_mask), 32'd0);

    // player 1 holes out
    map_mem[1601] = 2'd0;
    charge(1, 16'd90);
    check("p1_speed",   32'(ball_speed), 32'd1);
    check("p1_strokes", 32'(strokes[15:8]), 32'd1);
    wait_state("p1_holed", 3'd0);
    check("p1_holed_active", 32'(active_player), 32'd2);
    check("p1_holed_done",   32'(done_mask), 32'b010);
    check("p1_holed_speed",  32'(ball_speed), 32'd0);

    // player 2 creeps one LSB in y and stops
    map_mem[1601] = 2'd2;
    charge(1, 16'd90);
    wait_state("p2_stop", 3'd0);
    check("p2_stop_active", 32'(active_player), 32'd0);
    check("p0_own_x",       32'(ball_x), 32'h0184);
    check("p0_own_y",       32'(ball_y), 32'h0A00);
    check("p2_strokes",     32'(strokes[23:16]), 32'd1);

    // player 0 second stroke stops on grass; player 1 is skipped
    charge(1, 16'd0);
    check("p0_strokes2", 32'(strokes[7:0]), 32'd2);
    wait_state("p0_stop2", 3'd0);
    check("skip_done_active", 32'(active_player), 32'd2);
    check("p2_own_x",         32'(ball_x), 32'h0100);
    check("p2_own_y",         32'(ball_y), 32'h0A01);
`ifdef GOLF_STROKE_LIMIT_EN
    check("stroke_cap_done", 32'(done_mask), 32'b011);
`else
    check("stroke_cap_done", 32'(done_mask), 32'b010);
`endif

    // player 2 holes out, then the remaining player finishes
    map_mem[1601] = 2'd0;
    charge(1, 16'd90);
`ifdef GOLF_STROKE_LIMIT_EN
    wait_state("gover_state", 3'd7);
    check("gover_strokes", 32'(strokes), 32'h020102);
`else
    wait_state("p2_holed", 3'd0);
    check("p2_holed_active", 32'(active_player), 32'd0);
    check("p2_holed_done",   32'(done_mask), 32'b110);
    charge(1, 16'd0);
    wait_state("gover_state", 3'd7);
    check("gover_strokes", 32'(strokes), 32'h020103);
`endif
    check("gover_flag", 32'(game_over), 32'd1);
    check("gover_done", 32'(done_mask), 32'b111);

    charging_hit = 1'b1;
    repeat (3) @(negedge clk);
    charging_hit = 1'b0;
    check("gover_hold", 32'(state_out), 32'd7);

    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_state",   32'(state_out), 32'd0);
    check("rst2_done",    32'(done_mask), 32'd0);
    check("rst2_strokes", 32'(strokes), 32'd0);
    check("rst2_gover",   32'(game_over), 32'd0);
    check("rst2_x",       32'(ball_x), 32'h0100);
    rst_n = 1'b1;
    @(negedge clk);

    // reset while a trig request is outstanding
    trig_en = 1'b0;
    charge(1, 16'd45);
    check("mid_trig_req",   32'(bus.trig_req), 32'd1);
    check("mid_trig_angle", 32'(bus.trig_angle), 32'd45);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req",   32'(bus.trig_req), 32'd0);
    check("mid_rst_state", 32'(state_out), 32'd0);
    rst_n = 1'b1;
    trig_en = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_idle", 32'(state_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/golf_turn_engine.md
GOLF_TURN_ENGINE -- requirements
Module: golf_turn_engine

Interface
REQ-001 Parameters, one per line (name, default, meaning):
 NUM_PLAYERS, 2, balls/players (1-8); PW = max(1, clog2(NUM_PLAYERS))
 MAP_WIDTH, 160, tiles per row; MAP_HEIGHT, 90, rows
 START_X, 10 / START_Y, 10, start tile (integer) for every ball
 GRASS_DECEL, 2 / SAND_DECEL, 10, speed decrement per frame (8.8 LSBs)
 MAX_INIT_SPEED, 16'h0200, charge ceiling (8.8)
 MAX_SPEED_TO_SCORE, 16'h0080, speed below which a hole captures the ball
 CHARGE_DIV, 390625, cycles per 1-LSB charge step
 MAX_STROKES, 10, stroke cap (used only under REQ-022)
REQ-002 Ports, one per line (name, direction, width, meaning):
 clk_in  in  1  system clock
 rst_n_in  in  1  synchronous active-low reset
 new_frame  in  1  one-cycle frame tick
 charging_hit  in  1  level; high = charging, falling = release
 aim_angle  in  16  integer degrees 0-359
 tile_req / tile_addr  out  1 / 16  map read request; address
 tile_valid / tile_type  in  1 / 2  read response; 0 hole, 1 wall, 2 grass, 3 sand
 trig_req / trig_angle  out  1 / 16  cos/sin request; angle
 trig_valid, cos_abs, sin_abs, cos_sign, sin_sign  in  1,16,16,1,1  8.8 magnitudes; sign 1 = non-negative
 active_player  out  PW  current player
 ball_x, ball_y, ball_speed  out  16 each  active ball, 8.8
 ball_direction  out  16  integer degrees 0-359
 strokes  out  8*NUM_PLAYERS  per-player count, player p at [8p+7:8p]
 done_mask  out  NUM_PLAYERS  player finished
 state_out  out  3  FSM state code; game_over  out  1  all players done

Function
REQ-003 States/codes: RESTING=0, CHARGING=1, AIM=2, PROBE=3, UPDATE=4, REFLECT=5, NEXT_TURN=6, GAME_OVER=7.
REQ-004 RESTING: charging_hit high -> CHARGING, ball_speed=0, charge direction up.
REQ-005 CHARGING: every CHARGE_DIV cycles speed +1 up to MAX_INIT_SPEED, then -1 down to 0, repeating (triangle).
REQ-006 Release with speed 0 -> RESTING, no stroke; else strokes[active]+1 (saturate 255), ball_direction<=aim_angle, -> AIM.
REQ-007 AIM/REFLECT: hold trig_req=1, trig_angle=ball_direction until trig_valid; latch cos/sin; -> PROBE on next new_frame.
REQ-008 PROBE reads five tiles in order centre, x+1, y+1, x-1, y-1; one outstanding request; tile_req and tile_addr held stable until tile_valid.
REQ-009 tile_addr = (x>>8) + MAP_WIDTH*(y>>8) using neighbour integer coordinates.
REQ-010 Neighbour with integer coordinate <0, >=MAP_WIDTH or >=MAP_HEIGHT = wall, no read issued.
REQ-011 UPDATE priority: centre==0 and speed<MAX_SPEED_TO_SCORE -> holed; speed==0 -> stopped; first wall among x+,y+,x-,y- -> REFLECT; else move.
REQ-012 Holed: done_mask[active]<=1, speed 0, -> NEXT_TURN. Stopped: -> NEXT_TURN.
REQ-013 Wall: integer part -/+1 (x+/y+ subtract, x-/y- add), fraction 8'h80 on that axis; x walls dir<=(180-dir) mod 360, y walls dir<=(360-dir) mod 360.
REQ-014 Move: speed minus GRASS_DECEL or SAND_DECEL per centre tile, floored at 0 (hole tile: no decel); x +/- (speed*cos_abs)>>8 by cos_sign, y likewise with sin; -> PROBE on next new_frame.
REQ-015 new_frame during PROBE/UPDATE/AIM/REFLECT is dropped, never queued.
REQ-016 NEXT_TURN: next index (wrapping) whose done_mask bit is 0, -> RESTING; none -> GAME_OVER, game_over=1.
REQ-017 GAME_OVER held until reset; all inputs ignored.
REQ-018 tile_valid/trig_valid with no request pending are ignored.
REQ-019 Each player keeps its own ball position; ball_x/ball_y show active player's.

Reset
REQ-020 rst_n_in low at a clock edge: state RESTING, active_player 0, all balls (START_X<<8, START_Y<<8), speed 0, direction 0, strokes 0, done_mask 0, game_over 0, tile_req 0, trig_req 0.
REQ-021 Reset mid-handshake drops requests the same edge; late responses ignored per REQ-018.

Configuration
REQ-022 GOLF_STROKE_LIMIT_EN defined: ball stopping (not holed) with strokes[active]==MAX_STROKES sets done_mask[active]; undefined: no cap, strokes saturate at 255.

Verification
REQ-023 Hold charging_hit 3*CHARGE_DIV cycles, release -> speed 3, strokes[0]=1, state AIM.
REQ-024 Release at speed 0 -> RESTING, strokes unchanged.
REQ-025 Dir 0, x+ tile wall -> x int -1, frac 8'h80, dir 180, REFLECT.
REQ-026 Ball at x int 0, dir 180 -> x- treated wall with no tile_req for it, dir 0.
REQ-027 NUM_PLAYERS=3, player 1 done, player 0 stops -> active_player 2; all holed -> game_over=1, state 7.
REQ-028 With GOLF_STROKE_LIMIT_EN, MAX_STROKES=2: second stroke stops on grass -> done_mask[0]=1; without, done_mask[0]=0.
